// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has absolute priority, one external requester is buffered and issued in core-free cycles.
// Optional wait counter / sticky ext_starved flag under `DMEM_ARB_STARVE_CNT_EN.
//   state | meaning
//   IDLE  | buffer empty, ext_ready=1, accepting a new external request
//   PEND  | request buffered, waiting for a cycle with core_be==0 to issue
//   RESP  | external read issued last cycle, ext_rvalid=1 with mem_do
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 255
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [3:0]  core_be,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_di,
   output logic [31:0] core_do,
   output logic [3:0]  mem_be,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_di,
   input  logic [31:0] mem_do,
   input  logic        ext_valid,
   output logic        ext_ready,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   input  logic [3:0]  ext_be,
   output logic        ext_rvalid,
   output logic [31:0] ext_rdata
`ifdef DMEM_ARB_STARVE_CNT_EN
   ,
   output logic        ext_starved
`endif
);

   typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

   state_t      state_q, state_d;
   logic        buf_we_q, buf_we_d;
   logic [31:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_wdata_q, buf_wdata_d;
   logic [3:0]  buf_be_q, buf_be_d;
   logic        core_act;
   logic        issue;

   assign core_act   = |core_be;
   assign issue      = (state_q == PEND) && !core_act;
   assign ext_ready  = (state_q == IDLE);
   assign ext_rvalid = (state_q == RESP);
   assign core_do    = mem_do;
   assign ext_rdata  = mem_do;

   always_comb begin
      mem_be   = 4'b0000;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_di   = '0;
      if (core_act) begin
         mem_be   = core_be;
         mem_we   = core_we;
         mem_addr = core_addr;
         mem_di   = core_di;
      end else if (issue) begin
         // reads always fetch the full word; writes honour the buffered enables, even all-zero
         mem_be   = buf_we_q ? buf_be_q : 4'b1111;
         mem_we   = buf_we_q;
         mem_addr = buf_addr_q;
         mem_di   = buf_wdata_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_we_d    = buf_we_q;
      buf_addr_d  = buf_addr_q;
      buf_wdata_d = buf_wdata_q;
      buf_be_d    = buf_be_q;
      case (state_q)
         IDLE: begin
            if (ext_valid) begin
               state_d     = PEND;
               buf_we_d    = ext_we;
               buf_addr_d  = ext_addr;
               buf_wdata_d = ext_wdata;
               buf_be_d    = ext_be;
            end
         end
         PEND: begin
            if (issue) state_d = buf_we_q ? IDLE : RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= IDLE;
         buf_we_q    <= 1'b0;
         buf_addr_q  <= '0;
         buf_wdata_q <= '0;
         buf_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         buf_we_q    <= buf_we_d;
         buf_addr_q  <= buf_addr_d;
         buf_wdata_q <= buf_wdata_d;
         buf_be_q    <= buf_be_d;
      end
   end

`ifdef DMEM_ARB_STARVE_CNT_EN
   localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        starved_q, starved_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (issue)
         wait_cnt_d = '0;
      else if ((state_q == PEND) && (wait_cnt_q < LIMIT))
         wait_cnt_d = wait_cnt_q + 16'd1;
      starved_d = starved_q | (wait_cnt_d == LIMIT);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wait_cnt_q <= '0;
         starved_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         starved_q  <= starved_d;
      end
   end

   assign ext_starved = starved_q;
`endif

endmodule
